puf_majority_voter: RTL
=======================

Name: puf_majority_voter

Overview:
- Upstream front end of the PUF key path.
- Issues NUM_READS read requests to the raw PUF array and accumulates a per-bit count of ones.
- Outputs the per-bit majority value as the 256-bit response that feeds the scrambler input of the PUF datapath.
- Also reports an unstable-bit mask and count, which the controller uses for health checks before the LFSR/ECC stages run.

Parameters:
- WIDTH, 256, response width in bits; must match the datapath data_in width.
- NUM_READS, 7, number of PUF reads per vote; must be odd and at least 3.
- CNT_W, 3, per-bit counter width; equals clog2(NUM_READS+1).
- TIMEOUT, 1024, maximum cycles to wait for puf_valid after a request.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level start/hold; a drop aborts the operation or acknowledges done.
- puf_req  out  1  one-cycle read-request pulse to the PUF array.
- puf_valid  in  1  PUF array read-data strobe.
- puf_data  in  [0:WIDTH-1]  raw PUF response; sampled when puf_valid=1.
- data_out  out  [0:WIDTH-1]  majority-voted response.
- unstable_mask  out  [0:WIDTH-1]  1 where the bit did not read identically on every read.
- unstable_cnt  out  9  popcount of unstable_mask (0..256).
- done  out  1  vote complete (also high on error).
- error  out  1  PUF read timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Clock and reset are decided: one clock `clk`; reset `reset` is synchronous and active-high.
- States and transitions:
  - IDLE: enable=1 clears the bit counters, read_cnt and the timeout counter, then goes to REQ. Outputs keep their previous values.
  - REQ: puf_req=1 for exactly this cycle; timeout counter cleared; go to WAIT.
  - WAIT: if puf_valid=1, each bit counter[i] += puf_data[i] and read_cnt++.
    - If read_cnt was NUM_READS-1, go to VOTE; otherwise go to REQ.
    - If puf_valid=0, the timeout counter increments; on reaching TIMEOUT-1, go to ERR.
  - VOTE:
    - data_out[i] <= (counter[i] > NUM_READS/2).
    - unstable_mask[i] <= (counter[i] != 0) and (counter[i] != NUM_READS).
    - unstable_cnt <= popcount of the new mask.
    - Go to DONE.
  - DONE: done=1; hold while enable=1. On enable=0, go to IDLE and drop done the next cycle. data_out and mask are held.
  - ERR: done=1 and error=1; hold until enable=0, then go to IDLE with both cleared. data_out, unstable_mask and unstable_cnt are not updated on error.
- puf_valid outside WAIT is ignored. This includes a puf_valid in the same cycle as puf_req.
- enable=0 in REQ or WAIT: abort to IDLE next cycle; outputs unchanged, done stays 0.
- reset=1 in any state overrides all other inputs and forces the reset values next cycle.
- Counters cannot overflow: each bit counter increments at most NUM_READS times per vote.
- Latency: with puf_valid in the first WAIT cycle, done rises 2*NUM_READS+1 edges after the edge that samples enable=1 in IDLE. For NUM_READS=7 this is 15.
- Outputs are registered; no combinational path from inputs to outputs.
- Only one outstanding request: puf_req never re-asserts until a valid is received or the operation aborts.

Decomposition:
- Package puf_pkg holds:
  - the state enum (IDLE, REQ, WAIT, VOTE, DONE, ERR);
  - PUF_WIDTH=256;
  - the default NUM_READS and TIMEOUT values;
  - the CNT_W derivation function.
- One sub-module, puf_popcount: parameterised WIDTH, combinational adder tree producing the unstable_cnt value; registered in VOTE by the parent.
- The per-bit counters are a generate loop in the parent.

Test Plan:
- Stable PUF:
  - Stimulus: puf_data = 0xA5 repeated 32 times on all 7 reads, valid one cycle after each req.
  - Required: data_out = same pattern; unstable_mask = 0; unstable_cnt = 0; done at edge 15; exactly 7 puf_req pulses.
- Noisy PUF:
  - Stimulus: bit 0 = 1 on 4 of 7 reads; bit 1 = 1 on 3 of 7; bit 255 = 1 on 1 of 7; all other bits 0.
  - Required: data_out[0]=1, data_out[1]=0, data_out[255]=0; unstable_mask has bits 0, 1 and 255 set; unstable_cnt = 3.
- Timeout:
  - Stimulus: no puf_valid after the third request.
  - Required: done=1 and error=1 after TIMEOUT cycles in WAIT; data_out unchanged from the prior run.
  - Then enable=0: both flags clear one cycle later.
- Abort and restart:
  - Stimulus: enable drops after 4 reads, then re-asserts with all-ones data.
  - Required: no done during the aborted run; the restart yields data_out all ones, proving the counters were cleared.
- Reset and stray strobes:
  - Stimulus: reset asserted in WAIT; puf_valid pulsed during IDLE and DONE.
  - Required: all outputs 0 after reset; the stray strobes leave the counters and data_out unchanged.
- Back-to-back runs:
  - Stimulus: two runs with different patterns, enable toggled low for one cycle between them.
  - Required: second data_out reflects only the second run's data.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF majority-voter front end.
// Contents:
//   puf_state_e  controller state encoding
//   PUF_WIDTH    response width of the PUF datapath
//   DEF_*        default read count and read-timeout values
//   cnt_w_f      width of a counter that must hold 0..n
package puf_pkg;

  localparam int PUF_WIDTH     = 256;
  localparam int DEF_NUM_READS = 7;
  localparam int DEF_TIMEOUT   = 1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    VOTE = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } puf_state_e;

  function automatic int cnt_w_f(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_majority_voter_if.sv
// Bus between the PUF majority voter, its controller and the raw PUF array.
// Signals:
//   enable        controller -> voter  level start/hold, drop to abort or acknowledge
//   puf_req       voter -> PUF         one-cycle read request
//   puf_valid     PUF -> voter         read-data strobe
//   puf_data      PUF -> voter         raw response
//   data_out      voter -> datapath    majority-voted response
//   unstable_mask voter -> controller  bits that did not read identically
//   unstable_cnt  voter -> controller  popcount of unstable_mask
//   done / error  voter -> controller  completion and read-timeout flags
// Modports: slave is the voter, master is the controller/PUF side.
interface puf_majority_voter_if
  import puf_pkg::*;
#(
  parameter int WIDTH = PUF_WIDTH
);
  logic                         enable;
  logic                         puf_req;
  logic                         puf_valid;
  logic [0:WIDTH-1]             puf_data;
  logic [0:WIDTH-1]             data_out;
  logic [0:WIDTH-1]             unstable_mask;
  logic [$clog2(WIDTH+1)-1:0]   unstable_cnt;
  logic                         done;
  logic                         error;

  modport master (
    output enable, puf_valid, puf_data,
    input  puf_req, data_out, unstable_mask, unstable_cnt, done, error
  );

  modport slave (
    input  enable, puf_valid, puf_data,
    output puf_req, data_out, unstable_mask, unstable_cnt, done, error
  );
endinterface

// File: rtl/puf_popcount.sv
// Combinational population count of a bit vector, built as a balanced
// binary adder tree (leaves padded to a power of two with zeros).
// Ports:
//   i_bits   input vector
//   o_count  number of ones in i_bits
module puf_popcount #(
  parameter int WIDTH = 256,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [0:WIDTH-1] i_bits,
  output logic [OUT_W-1:0] o_count
);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int LEAVES = 1 << LEVELS;

  always_comb begin : p_tree
    // Heap layout: node n has children 2n+1 and 2n+2; leaves occupy the tail.
    logic [OUT_W-1:0] w_node [0:2*LEAVES-2];
    for (int n = 0; n < 2*LEAVES-1; n++) w_node[n] = '0;
    for (int k = 0; k < WIDTH; k++) w_node[LEAVES-1+k] = OUT_W'(i_bits[k]);
    for (int n = LEAVES-2; n >= 0; n--) w_node[n] = w_node[2*n+1] + w_node[2*n+2];
    o_count = w_node[0];
  end
endmodule

// File: rtl/puf_majority_voter.sv
// PUF majority voter: issues NUM_READS reads to the raw PUF array, counts
// ones per bit, then registers the per-bit majority as the response along
// with a mask/count of bits that did not read identically every time.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    puf_majority_voter_if.slave (enable, PUF request/data, results, flags)
module puf_majority_voter
  import puf_pkg::*;
#(
  parameter int WIDTH     = PUF_WIDTH,
  parameter int NUM_READS = DEF_NUM_READS,
  parameter int CNT_W     = cnt_w_f(NUM_READS),
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic                 clk,
  input logic                 reset,
  puf_majority_voter_if.slave bus
);
  localparam int UCNT_W = $clog2(WIDTH + 1);
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(NUM_READS - 1);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(NUM_READS / 2);
  localparam logic [CNT_W-1:0] ALL     = CNT_W'(NUM_READS);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  puf_state_e r_state, w_next;

  logic [CNT_W-1:0]  r_read_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_puf_req;
  logic              r_done;
  logic              r_error;
  logic [0:WIDTH-1]  r_data_out;
  logic [0:WIDTH-1]  r_mask;
  logic [UCNT_W-1:0] r_ucnt;

  logic              w_clr;
  logic              w_acc;
  logic              w_vote;
  logic [0:WIDTH-1]  w_maj;
  logic [0:WIDTH-1]  w_unst;
  logic [UCNT_W-1:0] w_pop;

  // Next-state and per-cycle strobes. Abort (enable low) wins over a
  // simultaneous puf_valid so an abandoned read never touches the counters.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_acc  = 1'b0;
    w_vote = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          w_clr  = 1'b1;
          w_next = REQ;
        end
      end
      REQ: begin
        w_next = bus.enable ? WAIT : IDLE;
      end
      WAIT: begin
        if (!bus.enable) begin
          w_next = IDLE;
        end else if (bus.puf_valid) begin
          w_acc  = 1'b1;
          w_next = (r_read_cnt == RD_LAST) ? VOTE : REQ;
        end else if (r_to_cnt == TO_LAST) begin
          w_next = ERR;
        end
      end
      VOTE: begin
        w_vote = 1'b1;
        w_next = DONE;
      end
      DONE, ERR: begin
        if (!bus.enable) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Control registers. Flag outputs are registered from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_read_cnt <= '0;
      r_to_cnt   <= '0;
      r_puf_req  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_puf_req <= (w_next == REQ);
      r_done    <= (w_next == DONE) || (w_next == ERR);
      r_error   <= (w_next == ERR);

      if (w_clr)      r_read_cnt <= '0;
      else if (w_acc) r_read_cnt <= r_read_cnt + CNT_W'(1);

      if (w_clr || (r_state == REQ)) begin
        r_to_cnt <= '0;
      end else if ((r_state == WAIT) && bus.enable && !bus.puf_valid &&
                   (r_to_cnt != TO_LAST)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Per-bit ones counters and their vote/stability decode. A counter sees
  // at most NUM_READS increments between clears, so it cannot wrap.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (reset)      r_cnt <= '0;
      else if (w_clr) r_cnt <= '0;
      else if (w_acc) r_cnt <= r_cnt + CNT_W'(bus.puf_data[gi]);
    end
    assign w_maj[gi]  = (r_cnt > HALF);
    assign w_unst[gi] = (r_cnt != '0) && (r_cnt != ALL);
  end

  puf_popcount #(
    .WIDTH (WIDTH),
    .OUT_W (UCNT_W)
  ) u_popcount (
    .i_bits  (w_unst),
    .o_count (w_pop)
  );

  // Result registers: only a completed vote updates them; abort and
  // timeout leave the previous response in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= '0;
      r_mask     <= '0;
      r_ucnt     <= '0;
    end else if (w_vote) begin
      r_data_out <= w_maj;
      r_mask     <= w_unst;
      r_ucnt     <= w_pop;
    end
  end

  assign bus.puf_req       = r_puf_req;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.data_out      = r_data_out;
  assign bus.unstable_mask = r_mask;
  assign bus.unstable_cnt  = r_ucnt;
endmodule
